sap_fetch_unit: RTL and testbench
=================================

Name: sap_fetch_unit

Overview:
- Upstream/downstream partner of the SAP-style control block (opcode in, 15-bit control word out).
- Holds the program counter (PC), memory address register (MAR) and instruction register (IR).
- Consumes the control word each cycle, drives the shared 8-bit bus, and returns IR[7:4] as the opcode to the control block.
- Sits between the control block, the RAM and the shared bus.

Parameters:
- ADDR_W, 4, width of PC, MAR and IR operand field.
- DATA_W, 8, bus and IR width; the opcode is always IR[DATA_W-1:DATA_W-4].
- IR_RST, 8'h10, IR reset value; the opcode field is NOP so the control block does not halt out of reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- ctrl  in  15  control word from the control block; bit map below.
- bus_in  in  DATA_W  shared bus value.
- bus_out  out  DATA_W  value this block drives onto the bus.
- bus_oe  out  1  bus_out is valid (EP or EI asserted).
- opcode  out  4  IR[7:4], wired to the control block opcode input.
- mem_addr  out  ADDR_W  MAR contents, to RAM address.
- pc  out  ADDR_W  current PC.
- halted  out  1  sticky halt flag.

Behaviour:
- Control bit map (bit 14 down to 0): CP, EP, LP, LM, RD, WR, LI, EI, LA, EA, SU, EU, LB, LO, HLT.
  - This block uses CP, EP, LP, LM, LI, EI and HLT.
  - All other bits are ignored.
- Reset (async, resetn=0): pc=0, MAR=0, IR=IR_RST, halted=0, bus_oe=0, bus_out=0. Reset takes effect mid-cycle regardless of ctrl.
- PC update:
  - CP=1: PC increments by 1, wrapping from 2^ADDR_W-1 to 0 with no flag.
  - LP=1: PC loads bus_in[ADDR_W-1:0].
  - LP and CP both 1: LP wins; the load happens and there is no increment.
- MAR: LM=1 loads bus_in[ADDR_W-1:0].
- IR: LI=1 loads bus_in[DATA_W-1:0].
- Same-cycle loads: LM and LI may both be 1 in the same cycle; both registers capture the same bus value.
- Bus drive (combinational from ctrl and registers):
  - EP=1: bus_out = {zeros, pc}.
  - else EI=1: bus_out = {zeros, IR[ADDR_W-1:0]}.
  - else bus_out = 0.
  - bus_oe = EP | EI.
  - EP and EI both 1: EP has priority.
- Bus source timing: a register loaded from the bus samples the bus_in value present before the edge. An EP-driven value therefore yields the old PC even when CP is set in the same cycle.
- Opcode: opcode = IR[7:4], combinational from the register, so it is visible the cycle after LI.
- Halt:
  - HLT=1 at an edge sets halted=1.
  - From the following edge onward, PC, MAR and IR ignore CP, LP, LM and LI.
  - The loads present in the same edge as HLT still take effect.
  - halted clears only on reset.
  - bus_out still follows EP/EI while halted.
- No other hidden state; every output is a pure function of the registers and ctrl.

Optional Feature:
- Macro: SAP_BUS_CHECK_EN.
- Enabled:
  - Adds output bus_conflict (1 bit, reset 0).
  - Set sticky at any edge where EP&EI=1, or where (EP|EI)=1 with WR=1 and RD=1 simultaneously.
  - Cleared only by reset.
- Disabled: the port is absent and no logic is generated; EP priority still applies.

Decomposition:
- Shared package sap_pkg:
  - control-bit index localparams (CTRL_CP=14 … CTRL_HLT=0);
  - opcode constants (OP_HLT=0, OP_NOP=1, OP_ADD=2, OP_SUB=3, OP_LDA=4, OP_OUT=5, OP_STA=6, OP_JMP=7);
  - IR_RST default.
- One sub-module, sap_program_counter: PC register with inc/load/halt-freeze and wrap. MAR, IR, bus mux and halt live in the top.

Test Plan:
- Reset then idle: resetn=0 for 30 ns, release with ctrl=0 -> pc=0, mem_addr=0, opcode=4'h1, halted=0, bus_oe=0.
- Fetch sequence: EP|LM, then CP, then RD|LI with bus_in=8'h2A -> mem_addr=0, pc=1, IR=8'h2A, opcode=4'h2, and with EI next bus_out=8'h0A.
- Wrap and priority:
  - 15 CP pulses from pc=1 -> pc=0.
  - LP|CP with bus_in=8'h07 -> pc=7, not 8.
- Jump (JMP path): IR=8'h7C, EI|LP -> pc=4'hC, bus_oe=1, bus_out=8'h0C.
- Halt freeze: HLT with LM, bus_in=8'h05 -> mem_addr=5, halted=1; subsequent CP/LI pulses leave pc and IR unchanged; async resetn pulse mid-cycle -> all reset values immediately.
- SAP_BUS_CHECK_EN build: EP|EI together -> bus_out={0,pc}, bus_conflict=1 after the edge and staying 1 until reset; disabled build compiles without the port.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP fetch/control slice: control-word bit
// positions, opcode values and the instruction register reset value.
package sap_pkg;

  localparam int unsigned CTRL_W = 15;

  localparam int unsigned CTRL_CP  = 14;
  localparam int unsigned CTRL_EP  = 13;
  localparam int unsigned CTRL_LP  = 12;
  localparam int unsigned CTRL_LM  = 11;
  localparam int unsigned CTRL_RD  = 10;
  localparam int unsigned CTRL_WR  = 9;
  localparam int unsigned CTRL_LI  = 8;
  localparam int unsigned CTRL_EI  = 7;
  localparam int unsigned CTRL_LA  = 6;
  localparam int unsigned CTRL_EA  = 5;
  localparam int unsigned CTRL_SU  = 4;
  localparam int unsigned CTRL_EU  = 3;
  localparam int unsigned CTRL_LB  = 2;
  localparam int unsigned CTRL_LO  = 1;
  localparam int unsigned CTRL_HLT = 0;

  typedef enum logic [3:0] {
    OP_HLT = 4'h0,
    OP_NOP = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_LDA = 4'h4,
    OP_OUT = 4'h5,
    OP_STA = 4'h6,
    OP_JMP = 4'h7
  } opcode_e;

  // Opcode field is NOP so the control block does not halt out of reset.
  localparam logic [7:0] IR_RST_DEFAULT = {OP_NOP, 4'h0};

endpackage

// File: rtl/sap_fetch_unit_if.sv
// Bus/control bundle between the SAP fetch unit and its neighbours.
// SAP_BUS_CHECK_EN adds the bus_conflict status signal.
interface sap_fetch_unit_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic [14:0]       ctrl;
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] pc;
  logic              halted;
`ifdef SAP_BUS_CHECK_EN
  logic              bus_conflict;
`endif

  modport master (
    output ctrl, bus_in,
    input  bus_out, bus_oe, opcode, mem_addr, pc, halted
`ifdef SAP_BUS_CHECK_EN
    , input bus_conflict
`endif
  );

  modport slave (
    input  ctrl, bus_in,
    output bus_out, bus_oe, opcode, mem_addr, pc, halted
`ifdef SAP_BUS_CHECK_EN
    , output bus_conflict
`endif
  );
endinterface

// File: rtl/sap_program_counter.sv
// Program counter: load beats increment, wraps silently, frozen once halted.
module sap_program_counter #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inc,
  input  logic              load,
  input  logic              freeze,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);
  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (!freeze) begin
      if (load)     pc_d = load_val;
      else if (inc) pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pc_q <= '0;
    else         pc_q <= pc_d;
  end

  assign pc = pc_q;
endmodule

// File: rtl/sap_fetch_unit.sv
// SAP fetch unit: PC, MAR, IR, bus drive and sticky halt.
// Define SAP_BUS_CHECK_EN to add the sticky bus_conflict flag.
module sap_fetch_unit
  import sap_pkg::*;
#(
  parameter int unsigned      ADDR_W = 4,
  parameter int unsigned      DATA_W = 8,
  parameter logic [DATA_W-1:0] IR_RST = DATA_W'(IR_RST_DEFAULT)
) (
  input logic              clk,
  input logic              resetn,
  sap_fetch_unit_if.slave  bus
);
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              halted_q, halted_d;
  logic [ADDR_W-1:0] pc_w;
  logic cp, ep, lp, lm, li, ei, hlt;

  assign cp  = bus.ctrl[CTRL_CP];
  assign ep  = bus.ctrl[CTRL_EP];
  assign lp  = bus.ctrl[CTRL_LP];
  assign lm  = bus.ctrl[CTRL_LM];
  assign li  = bus.ctrl[CTRL_LI];
  assign ei  = bus.ctrl[CTRL_EI];
  assign hlt = bus.ctrl[CTRL_HLT];

  sap_program_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clk      (clk),
    .resetn   (resetn),
    .inc      (cp),
    .load     (lp),
    .freeze   (halted_q),
    .load_val (bus.bus_in[ADDR_W-1:0]),
    .pc       (pc_w)
  );

  // Freeze keys off the registered flag, so loads sharing the HLT edge land.
  always_comb begin
    mar_d    = mar_q;
    ir_d     = ir_q;
    halted_d = halted_q | hlt;
    if (!halted_q) begin
      if (lm) mar_d = bus.bus_in[ADDR_W-1:0];
      if (li) ir_d  = bus.bus_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mar_q    <= '0;
      ir_q     <= IR_RST;
      halted_q <= 1'b0;
    end else begin
      mar_q    <= mar_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    bus.bus_out = '0;
    if (ep)      bus.bus_out = {{(DATA_W-ADDR_W){1'b0}}, pc_w};
    else if (ei) bus.bus_out = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
  end

  assign bus.bus_oe   = ep | ei;
  assign bus.opcode   = ir_q[DATA_W-1 -: 4];
  assign bus.mem_addr = mar_q;
  assign bus.pc       = pc_w;
  assign bus.halted   = halted_q;

`ifdef SAP_BUS_CHECK_EN
  logic conflict_q, conflict_d;
  logic rd, wr;

  assign rd = bus.ctrl[CTRL_RD];
  assign wr = bus.ctrl[CTRL_WR];

  always_comb begin
    conflict_d = conflict_q | (ep & ei) | ((ep | ei) & wr & rd);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) conflict_q <= 1'b0;
    else         conflict_q <= conflict_d;
  end

  assign bus.bus_conflict = conflict_q;
`endif
endmodule

// File: tb/tb_sap_fetch_unit.sv
// Directed plus randomized bench for sap_fetch_unit against a behavioural model.
module tb_sap_fetch_unit;
  localparam logic [14:0] CP  = 15'h4000;
  localparam logic [14:0] EP  = 15'h2000;
  localparam logic [14:0] LP  = 15'h1000;
  localparam logic [14:0] LM  = 15'h0800;
  localparam logic [14:0] RD  = 15'h0400;
  localparam logic [14:0] WR  = 15'h0200;
  localparam logic [14:0] LI  = 15'h0100;
  localparam logic [14:0] EI  = 15'h0080;
  localparam logic [14:0] HLT = 15'h0001;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Behavioural model of the architectural state.
  int   m_pc, m_mar, m_ir, m_halt, m_conf;

  sap_fetch_unit_if #(.ADDR_W(4), .DATA_W(8)) bif ();

  sap_fetch_unit #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_bus(input logic [14:0] c);
    if ((c & EP) != 0) return m_pc;
    if ((c & EI) != 0) return m_ir % 16;
    return 0;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_mar = 0; m_ir = 8'h10; m_halt = 0; m_conf = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".pc"},     8'(bif.pc),       8'(m_pc));
    chk({tag, ".mar"},    8'(bif.mem_addr), 8'(m_mar));
    chk({tag, ".opcode"}, 8'(bif.opcode),   8'(m_ir / 16));
    chk({tag, ".halted"}, 8'(bif.halted),   8'(m_halt));
`ifdef SAP_BUS_CHECK_EN
    chk({tag, ".conflict"}, 8'(bif.bus_conflict), 8'(m_conf));
`endif
  endtask

  // One clock: drive at the falling edge, check bus drive before the rising
  // edge, advance the model, then check registers just after it.
  task automatic step(input string tag, input logic [14:0] c, input logic [7:0] b);
    int bv, bin;
    bit oe;
    @(negedge clk);
    bif.ctrl = c;
    oe = ((c & (EP | EI)) != 0);
    bv = model_bus(c);
    bin = oe ? bv : int'(b);
    bif.bus_in = 8'(bin);
    #1;
    chk({tag, ".bus_out"}, bif.bus_out, 8'(bv));
    chk({tag, ".bus_oe"},  8'(bif.bus_oe), 8'(oe));
    if (((c & EP) != 0 && (c & EI) != 0) || (oe && (c & RD) != 0 && (c & WR) != 0))
      m_conf = 1;
    if (m_halt == 0) begin
      if ((c & LP) != 0)      m_pc = bin % 16;
      else if ((c & CP) != 0) m_pc = (m_pc + 1) % 16;
      if ((c & LM) != 0) m_mar = bin % 16;
      if ((c & LI) != 0) m_ir  = bin % 256;
    end
    if ((c & HLT) != 0) m_halt = 1;
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  initial begin
    bif.ctrl = '0;
    bif.bus_in = '0;
    model_reset();

    // Reset then idle
    #30 resetn = 1'b1;
    #1;
    check_regs("reset");
    chk("reset.bus_oe", 8'(bif.bus_oe), 8'h00);
    chk("reset.opcode_nop", 8'(bif.opcode), 8'h01);
    step("idle", '0, 8'h00);

    // Fetch: EP|LM, CP, RD|LI, then EI shows the operand
    step("fetch_ep_lm", EP | LM, 8'h00);
    chk("fetch.mar0", 8'(bif.mem_addr), 8'h00);
    step("fetch_cp", CP, 8'h00);
    chk("fetch.pc1", 8'(bif.pc), 8'h01);
    step("fetch_li", RD | LI, 8'h2A);
    chk("fetch.op2", 8'(bif.opcode), 8'h02);
    step("fetch_ei", EI, 8'h00);
    chk("fetch.ei_out", bif.bus_out, 8'h0A);

    // Wrap and LP-over-CP priority
    for (int i = 0; i < 15; i++) step("wrap", CP, 8'h00);
    chk("wrap.pc0", 8'(bif.pc), 8'h00);
    step("lp_cp", LP | CP, 8'h07);
    chk("lp_cp.pc7", 8'(bif.pc), 8'h07);

    // EP with CP in the same cycle puts the old PC on the bus
    step("ep_cp_lm", EP | CP | LM, 8'h00);
    chk("ep_cp.mar7", 8'(bif.mem_addr), 8'h07);
    chk("ep_cp.pc8", 8'(bif.pc), 8'h08);

    // Jump path
    step("jmp_li", LI, 8'h7C);
    @(negedge clk);
    bif.ctrl = EI | LP;
    bif.bus_in = 8'h0C;
    #1;
    chk("jmp.bus_oe", 8'(bif.bus_oe), 8'h01);
    chk("jmp.bus_out", bif.bus_out, 8'h0C);
    step("jmp_ei_lp", EI | LP, 8'h00);
    chk("jmp.pcC", 8'(bif.pc), 8'h0C);

    // Randomized traffic, halt masked off
    for (int i = 0; i < 200; i++)
      step("rand", 15'($urandom) & 15'h7FFE, 8'($urandom));

    // Halt with a same-edge MAR load, then frozen state
    step("halt_lm", HLT | LM, 8'h05);
    chk("halt.mar5", 8'(bif.mem_addr), 8'h05);
    chk("halt.flag", 8'(bif.halted), 8'h01);
    step("halt_cp", CP, 8'h00);
    step("halt_li", LI, 8'hF3);
    step("halt_lp", LP | LM, 8'h09);
    for (int i = 0; i < 20; i++)
      step("halt_rand", 15'($urandom), 8'($urandom));
    step("halt_ep", EP, 8'h00);

    // Async reset mid-cycle
    @(negedge clk);
    bif.ctrl = '0;
    #2 resetn = 1'b0;
    model_reset();
    #1;
    check_regs("async_rst");
    chk("async_rst.bus_out", bif.bus_out, 8'h00);
    chk("async_rst.bus_oe", 8'(bif.bus_oe), 8'h00);
    #10 resetn = 1'b1;
    step("post_rst", CP, 8'h00);

`ifdef SAP_BUS_CHECK_EN
    step("conflict", EP | EI, 8'h00);
    chk("conflict.set", 8'(bif.bus_conflict), 8'h01);
    step("conflict_hold", '0, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
